// File: rtl/bcd_conv_pkg.sv
// Shared constants and FSM state type for the arbitrated binary-to-BCD converter.
package bcd_conv_pkg;

    localparam int BIN_W        = 16;
    localparam int BCD_DIGITS   = 4;
    localparam int BCD_W        = 16;
    localparam int SHIFT_CYCLES = 16;
    localparam int CNT_W        = $clog2(SHIFT_CYCLES);

    localparam logic [BIN_W-1:0] MAX_DEC = 16'd9999;
    localparam logic [BCD_W-1:0] SAT_BCD = 16'h9999;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RESP
    } conv_state_t;

endpackage

// File: rtl/bcd_dd_engine.sv
// Serial double-dabble engine: one add-3/shift step per cycle over SHIFT_CYCLES cycles.
module bcd_dd_engine
    import bcd_conv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W+BIN_W-1:0] scratch_q;
    logic [BCD_W+BIN_W-1:0] adjusted;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [CNT_W-1:0]       cnt_q;
    logic                   run_q;
    logic                   last_step;

    // Digits are corrected independently; a 4-bit add never carries into the next digit.
    always_comb begin
        adjusted = scratch_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (scratch_q[BIN_W + 4*d +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*d +: 4] = scratch_q[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        shifted = adjusted << 1;
    end

    assign last_step = (cnt_q == CNT_W'(SHIFT_CYCLES - 1));
    assign busy_o    = run_q;
    assign done_o    = run_q && last_step;
    assign bcd_o     = shifted[BCD_W+BIN_W-1:BIN_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scratch_q <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else if (start_i) begin
            scratch_q <= {{BCD_W{1'b0}}, bin_i};
            cnt_q     <= '0;
            run_q     <= 1'b1;
        end else if (run_q) begin
            scratch_q <= shifted;
            cnt_q     <= cnt_q + 1'b1;
            if (last_step) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one double-dabble engine among NUM_REQ requesters,
// with a held, ID-tagged response register and saturation above 9999.
module bcd_conv_arbiter
    import bcd_conv_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*BIN_W-1:0] req_bin_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [BCD_W-1:0]         rsp_bcd_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     rsp_ovf_o,
    output logic                     busy_o
);

    conv_state_t      state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    logic [BIN_W-1:0]   bin_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic [BIN_W-1:0]   sel_bin;

    logic             eng_start;
    logic             eng_busy;
    logic             eng_done;
    logic [BCD_W-1:0] eng_bcd;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bin_arr[i] = req_bin_i[BIN_W*i +: BIN_W];
        end
        sel_bin = bin_arr[winner];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rsp_bcd_d    = rsp_bcd_q;
        rsp_ovf_d    = rsp_ovf_q;
        eng_start    = 1'b0;
        req_ready_o  = '0;
        case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so nothing looks accepted.
                req_ready_o = grant & {NUM_REQ{rst_ni}};
                if (found) begin
                    last_grant_d = winner;
                    id_d         = winner;
                    if (sel_bin > MAX_DEC) begin
                        rsp_bcd_d = SAT_BCD;
                        rsp_ovf_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        eng_start = 1'b1;
                        state_d   = CONV;
                    end
                end
            end
            CONV: begin
                if (eng_done) begin
                    rsp_bcd_d = eng_bcd;
                    rsp_ovf_d = 1'b0;
                    state_d   = RESP;
                end else if (!eng_busy) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            rsp_bcd_q    <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rsp_bcd_q    <= rsp_bcd_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    bcd_dd_engine u_engine (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (eng_start),
        .bin_i   (sel_bin),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .bcd_o   (eng_bcd)
    );

    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign rsp_bcd_o   = rsp_bcd_q;
    assign rsp_id_o    = id_q;
    assign rsp_ovf_o   = rsp_ovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with hand-computed BCD results.
module tb_bcd_conv_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_bin = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_bcd;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bcd_conv_arbiter #(.NUM_REQ(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_bin_i   (req_bin),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_bcd_o   (rsp_bcd),
        .rsp_id_o    (rsp_id),
        .rsp_ovf_o   (rsp_ovf),
        .busy_o      (busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic v, input logic [15:0] bin);
        req_valid[ch]       = v;
        req_bin[16*ch +: 16] = bin;
    endtask

    task automatic doReset();
        rst_ni    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
    endtask

    // Called in cycle T+startLat; waits (bounded) for the response and checks it.
    task automatic expectRsp(input string tag, input logic [15:0] bcd, input logic [1:0] id,
                             input logic ovf, input int expLat, input int startLat);
        int lat;
        lat = startLat;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_valid"}, rsp_valid, 1);
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_bcd"}, rsp_bcd, bcd);
        checkOutput({tag, "_id"}, rsp_id, id);
        checkOutput({tag, "_ovf"}, rsp_ovf, ovf);
    endtask

    task automatic convert(input string tag, input int ch, input logic [15:0] bin,
                           input logic [15:0] bcd, input logic ovf, input int expLat);
        applyStimulus(ch, 1'b1, bin);
        #1;
        checkOutput({tag, "_grant"}, req_ready, 32'(1 << ch));
        tick();
        applyStimulus(ch, 1'b0, bin);
        expectRsp(tag, bcd, 2'(ch), ovf, expLat, 1);
        tick();
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [15:0] vals [4];
        logic [15:0] bcds [4];
        int prev;
        int w;
        vals[0] = 16'd1;  vals[1] = 16'd22;  vals[2] = 16'd333;  vals[3] = 16'd4444;
        bcds[0] = 16'h0001; bcds[1] = 16'h0022; bcds[2] = 16'h0333; bcds[3] = 16'h4444;

        // Reset values
        #2;
        checkOutput("rst_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bcd", rsp_bcd, 0);
        checkOutput("rst_id", rsp_id, 0);
        checkOutput("rst_ovf", rsp_ovf, 0);
        checkOutput("rst_ready", req_ready, 0);
        doReset();

        convert("t1", 0, 16'd1234, 16'h1234, 1'b0, 17);

        // Round robin with all four requesters valid
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, vals[i]);
        #1;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (!(|req_ready) && w < 30) begin
                tick();
                w++;
            end
            checkOutput("rr_grant", req_ready, 32'(1 << (g % 4)));
            if (g > 0) checkOutput("rr_spacing", cyc - prev, 18);
            prev = cyc;
            tick();
            expectRsp("rr", bcds[g % 4], 2'(g % 4), 1'b0, 17, 1);
        end
        req_valid = '0;
        tick();

        // Boundaries
        convert("zero", 0, 16'd0, 16'h0000, 1'b0, 17);
        convert("max", 1, 16'd9999, 16'h9999, 1'b0, 17);
        convert("ovf10k", 2, 16'd10000, 16'h9999, 1'b1, 1);
        convert("ovf64k", 2, 16'd65535, 16'h9999, 1'b1, 1);

        // Back-pressure while ch1 waits
        rsp_ready = 1'b0;
        applyStimulus(0, 1'b1, 16'd56);
        #1;
        checkOutput("bp_grant0", req_ready, 4'b0001);
        tick();
        applyStimulus(0, 1'b0, 16'd56);
        applyStimulus(1, 1'b1, 16'd789);
        expectRsp("bp", 16'h0056, 2'd0, 1'b0, 17, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold", {rsp_valid, rsp_ovf, rsp_id, rsp_bcd}, {1'b1, 1'b0, 2'd0, 16'h0056});
            checkOutput("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_grant1", req_ready, 4'b0010);
        tick();
        applyStimulus(1, 1'b0, 16'd789);
        expectRsp("bp_ch1", 16'h0789, 2'd1, 1'b0, 17, 1);
        tick();

        // Asynchronous reset in the middle of a conversion
        applyStimulus(1, 1'b1, 16'd100);
        #1;
        checkOutput("ar_grant", req_ready, 4'b0010);
        tick();
        applyStimulus(1, 1'b0, 16'd100);
        repeat (7) tick();
        checkOutput("ar_busy_pre", busy, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("ar_valid", rsp_valid, 0);
        checkOutput("ar_busy", busy, 0);
        applyStimulus(3, 1'b1, 16'd3210);
        applyStimulus(0, 1'b1, 16'd7);
        #1;
        checkOutput("ar_ready_in_rst", req_ready, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        checkOutput("ar_grant0", req_ready, 4'b0001);
        checkOutput("ar_no_rsp", rsp_valid, 0);
        tick();
        applyStimulus(0, 1'b0, 16'd7);
        expectRsp("ar_ch0", 16'h0007, 2'd0, 1'b0, 17, 1);
        tick();
        checkOutput("ar_grant3", req_ready, 4'b1000);
        tick();
        applyStimulus(3, 1'b0, 16'd3210);
        expectRsp("ar_ch3", 16'h3210, 2'd3, 1'b0, 17, 1);
        tick();

        // Fairness: ch0 stays valid, ch2 arrives mid-conversion
        applyStimulus(0, 1'b1, 16'd5);
        #1;
        checkOutput("fair_grant0", req_ready, 4'b0001);
        tick();
        repeat (3) tick();
        applyStimulus(2, 1'b1, 16'd42);
        expectRsp("fair_ch0", 16'h0005, 2'd0, 1'b0, 17, 4);
        tick();
        checkOutput("fair_grant2", req_ready, 4'b0100);
        tick();
        applyStimulus(2, 1'b0, 16'd42);
        expectRsp("fair_ch2", 16'h0042, 2'd2, 1'b0, 17, 1);
        tick();
        checkOutput("fair_grant0b", req_ready, 4'b0001);
        applyStimulus(0, 1'b0, 16'd5);
        tick();
        checkOutput("fair_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
